// File: rtl/beep_player_if.sv
// beep_player_if: control and status bundle between the key/UART controller and beep_player.
//   master (controller): drives wr_en/wr_addr/wr_data (song RAM write), start/stop pulses,
//                        loop, len (last entry index), duty_sel; reads busy, done, note_idx.
//   slave (beep_player): the reverse directions.
interface beep_player_if #(parameter int ADDR_W = 4);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              start;
    logic              stop;
    logic              loop;
    logic [ADDR_W-1:0] len;
    logic [1:0]        duty_sel;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] note_idx;
    modport master (
        output wr_en, wr_addr, wr_data, start, stop, loop, len, duty_sel,
        input  busy, done, note_idx
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, start, stop, loop, len, duty_sel,
        output busy, done, note_idx
    );
endinterface

// File: rtl/beep_player.sv
// beep_player: melody engine playing song RAM entries on a PWM buzzer output.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   ctl (slave)        : song RAM write port, start/stop/loop/len/duty_sel control,
//                        busy/done/note_idx status
//   beep               : registered buzzer drive
// Entry format: [7:6] octave (3 acts as 2), [5:3] note (0 rest, 1..7 DO..XI), [2:0] beats-1.
module beep_player #(
    parameter logic [24:0] UNIT_MAX = 25'd24_999_999,
    parameter int          ADDR_W   = 4,
    parameter logic [17:0] DO       = 18'd190839,
    parameter logic [17:0] RI       = 18'd170067,
    parameter logic [17:0] MI       = 18'd151514,
    parameter logic [17:0] FA       = 18'd143265,
    parameter logic [17:0] SO       = 18'd127550,
    parameter logic [17:0] LA       = 18'd113635,
    parameter logic [17:0] XI       = 18'd101213
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    beep_player_if.slave  ctl,
    output logic          beep
);
    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;
    state_t            state;
    logic [7:0]        mem [2**ADDR_W];
    logic [7:0]        ent;
    logic [1:0]        duty;
    logic [ADDR_W-1:0] idx;
    logic [17:0]       freq_cnt;
    logic [24:0]       unit_cnt;
    logic [2:0]        beat_cnt;
    logic [17:0]       base;
    logic [17:0]       period;
    logic [17:0]       high_len;
    logic [1:0]        oct;
    logic              note_end;

    assign ctl.note_idx = idx;

    // Song RAM is deliberately not reset; entries persist across playback.
    always_ff @(posedge sys_clk) begin
        if (ctl.wr_en) mem[ctl.wr_addr] <= ctl.wr_data;
    end

    always_comb begin
        case (ent[5:3])
            3'd1:    base = DO;
            3'd2:    base = RI;
            3'd3:    base = MI;
            3'd4:    base = FA;
            3'd5:    base = SO;
            3'd6:    base = LA;
            3'd7:    base = XI;
            default: base = 18'd0;
        endcase
        oct      = ent[5:3] == 3'd0 ? 2'd0 : ent[7:6] == 2'd3 ? 2'd2 : ent[7:6];
        period   = ((base + 18'd1) >> oct) - 18'd1;
        high_len = (period + 18'd1) >> ({1'b0, duty} + 3'd1);
        note_end = beat_cnt == ent[2:0] && unit_cnt == UNIT_MAX;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            ent      <= 8'd0;
            duty     <= 2'd0;
            idx      <= '0;
            freq_cnt <= 18'd0;
            unit_cnt <= 25'd0;
            beat_cnt <= 3'd0;
            beep     <= 1'b0;
            ctl.busy <= 1'b0;
            ctl.done <= 1'b0;
        end else begin
            ctl.done <= 1'b0;
            beep     <= 1'b0;
            case (state)
                IDLE: if (ctl.start && !ctl.stop) begin
                    state    <= LOAD;
                    idx      <= '0;
                    ctl.busy <= 1'b1;
                end
                LOAD: begin
                    ent      <= mem[idx];
                    duty     <= ctl.duty_sel;
                    freq_cnt <= 18'd0;
                    unit_cnt <= 25'd0;
                    beat_cnt <= 3'd0;
                    state    <= ctl.stop ? IDLE : PLAY;
                    ctl.busy <= !ctl.stop;
                end
                PLAY: if (ctl.stop) begin
                    state    <= IDLE;
                    ctl.busy <= 1'b0;
                end else begin
                    beep     <= ent[5:3] != 3'd0 && freq_cnt < high_len;
                    freq_cnt <= freq_cnt == period ? 18'd0 : freq_cnt + 18'd1;
                    unit_cnt <= unit_cnt == UNIT_MAX ? 25'd0 : unit_cnt + 25'd1;
                    if (unit_cnt == UNIT_MAX) beat_cnt <= beat_cnt + 3'd1;
                    // len and loop are taken live at each note end
                    if (note_end) begin
                        if (idx < ctl.len) begin
                            idx   <= idx + 1'b1;
                            state <= LOAD;
                        end else if (ctl.loop) begin
                            idx   <= '0;
                            state <= LOAD;
                        end else begin
                            state    <= IDLE;
                            ctl.busy <= 1'b0;
                            ctl.done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_beep_player.sv
// tb_beep_player: directed bench for beep_player with UNIT_MAX=9 and DO=7 so that
// one beat is 10 clocks and a base-octave DO has an 8-clock period.
module tb_beep_player;
    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        beep;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] tr;
    int          bc;
    int          dc;

    beep_player_if #(.ADDR_W(4)) bus();

    beep_player #(.UNIT_MAX(25'd9), .ADDR_W(4), .DO(18'd7)) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .ctl(bus),
        .beep(beep)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        bus.wr_en = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick;
        bus.wr_en = 1'b0;
    endtask

    // One-shot playback of a single entry; trace bit per observed cycle, MSB first.
    task automatic play(input logic [7:0] e, input logic [1:0] d, input int n,
                        output logic [31:0] t, output int b, output int dn);
        wr(4'd0, e);
        bus.len = 4'd0;
        bus.loop = 1'b0;
        bus.duty_sel = d;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        t = 32'd0;
        b = int'(bus.busy);
        dn = int'(bus.done);
        for (int i = 0; i < n; i++) begin
            tick;
            t = {t[30:0], beep};
            b += int'(bus.busy);
            dn += int'(bus.done);
        end
    endtask

    initial begin
        bus.wr_en = 1'b0;
        bus.wr_addr = 4'd0;
        bus.wr_data = 8'd0;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.loop = 1'b0;
        bus.len = 4'd0;
        bus.duty_sel = 2'd0;
        tick;
        tick;
        check("rst_beep", 32'(beep), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_idx", 32'(bus.note_idx), 32'd0);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick;
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_beep", 32'(beep), 32'd0);

        play(8'h08, 2'd0, 14, tr, bc, dc);
        check("do_half_beep", tr, 32'b01111000011000);
        check("do_half_busy", bc, 11);
        check("do_half_done", dc, 1);

        play(8'h08, 2'd1, 14, tr, bc, dc);
        check("do_quarter_beep", tr, 32'b01100000011000);
        check("do_quarter_busy", bc, 11);

        play(8'h01, 2'd0, 24, tr, bc, dc);
        check("rest_beep", tr, 32'd0);
        check("rest_busy", bc, 21);
        check("rest_done", dc, 1);

        play(8'h48, 2'd0, 14, tr, bc, dc);
        check("oct1_beep", tr, 32'b01100110011000);

        play(8'hC8, 2'd0, 14, tr, bc, dc);
        check("oct3_beep", tr, 32'b01010101010000);
        check("oct3_done", dc, 1);

        bus.start = 1'b1;
        bus.stop = 1'b1;
        tick;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        check("start_stop_busy", 32'(bus.busy), 32'd0);

        wr(4'd0, 8'h08);
        wr(4'd1, 8'h48);
        bus.len = 4'd1;
        bus.loop = 1'b1;
        bus.duty_sel = 2'd0;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        dc = 0;
        for (int j = 1; j <= 34; j++) begin
            tick;
            dc += int'(bus.done);
            if (j == 5) check("loop_idx_a", 32'(bus.note_idx), 32'd0);
            if (j == 16) check("loop_idx_b", 32'(bus.note_idx), 32'd1);
            if (j == 27) check("loop_idx_c", 32'(bus.note_idx), 32'd0);
            if (j == 33) check("loop_idx_d", 32'(bus.note_idx), 32'd1);
            if (j == 14) begin
                bus.start = 1'b0;
                check("busy_start_idx", 32'(bus.note_idx), 32'd1);
                check("busy_start_busy", 32'(bus.busy), 32'd1);
            end
            if (j == 13) bus.start = 1'b1;
        end
        bus.stop = 1'b1;
        tick;
        bus.stop = 1'b0;
        check("stop_beep", 32'(beep), 32'd0);
        check("stop_busy", 32'(bus.busy), 32'd0);
        check("stop_done", 32'(bus.done), 32'd0);
        tick;
        dc += int'(bus.done);
        check("loop_no_done", dc, 0);

        wr(4'd0, 8'h08);
        bus.len = 4'd0;
        bus.loop = 1'b1;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        tr = {31'd0, beep};
        for (int j = 1; j <= 22; j++) begin
            tick;
            tr = {tr[30:0], beep};
            if (j == 4) bus.wr_en = 1'b0;
            if (j == 3) begin
                bus.wr_en = 1'b1;
                bus.wr_addr = 4'd0;
                bus.wr_data = 8'hC8;
            end
        end
        check("wr_next_load", tr, 32'b00111100001101010101010);
        bus.stop = 1'b1;
        tick;
        bus.stop = 1'b0;

        wr(4'd0, 8'h08);
        wr(4'd1, 8'h48);
        bus.len = 4'd1;
        bus.loop = 1'b1;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        for (int j = 1; j <= 13; j++) tick;
        check("pre_rst_beep", 32'(beep), 32'd1);
        #2 sys_rst_n = 1'b0;
        #1;
        check("mid_rst_beep", 32'(beep), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_idx", 32'(bus.note_idx), 32'd0);
        tick;
        sys_rst_n = 1'b1;
        tick;
        tick;
        check("post_rst_busy", 32'(bus.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
